snake_body: RTL and testbench
=============================

SNAKE_BODY -- requirements
Module: snake_body

Interface
REQ-001 Parameter MAX_LEN, default 16, SHALL set the maximum number of stored segments (legal range 4..16).
REQ-002 Parameter INIT_LEN, default 3, SHALL set the body length loaded at reset (legal range 1..MAX_LEN).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 head_x  input  4  SHALL be the new head column from the movement stage.
REQ-006 head_y  input  4  SHALL be the new head row from the movement stage.
REQ-007 step  input  1  SHALL be a one-cycle pulse qualifying head_x/head_y as a new head position.
REQ-008 food_x, food_y  input  4 each  SHALL be the current food cell.
REQ-009 food_valid  input  1  SHALL qualify food_x/food_y.
REQ-010 row_sel  input  4  SHALL select the display row to read out.
REQ-011 row_bits  output  16  SHALL be the occupancy map of the selected row; bit i set means a segment occupies (x=i, y=row_sel).
REQ-012 len  output  5  SHALL be the current body length.
REQ-013 ate  output  1  SHALL be a one-cycle pulse indicating that food was consumed.
REQ-014 dead  output  1  SHALL be a sticky flag indicating a self-collision.

Function
REQ-015 The block SHALL hold segment registers seg[0..MAX_LEN-1] of 8 bits each ({x,y}); seg[0] is the head, and seg[len-1] is the tail.
REQ-016 Entries at index >= len SHALL be don't-care and SHALL NOT contribute to row_bits or to collision checks.
REQ-017 On a rising edge with step=1 and dead=0, the block SHALL shift seg[k] <= seg[k-1] for k=1..MAX_LEN-1 and load seg[0] <= {head_x,head_y}.
REQ-018 eat SHALL be the condition food_valid=1 and {head_x,head_y}=={food_x,food_y}, evaluated in the step cycle.
REQ-019 When eat holds, len SHALL increment by 1, saturating at MAX_LEN; ate SHALL pulse high for exactly the cycle after the step edge, including at saturation.
REQ-020 When eat does not hold, len SHALL be unchanged; the former tail drops off through the shift.
REQ-021 Collision SHALL compare the new head against pre-shift seg[0..len-2] when not eating, and against seg[0..len-1] when eating; the vacating tail cell is therefore legal.
REQ-022 On collision, dead SHALL be set at that edge and hold until reset; seg and len SHALL still update on the colliding step.
REQ-023 A step arriving while dead=1 SHALL be ignored: no shift, no len change, and no ate pulse.
REQ-024 Coordinates SHALL be treated modulo 16; there is no wall detection in this block, and a 15->0 wrap is an ordinary move.
REQ-025 row_bits SHALL be registered, with one-cycle latency from row_sel, and SHALL reflect the segment state before any update occurring on that same edge.
REQ-026 A step on consecutive cycles SHALL be accepted every cycle; there is no busy or backpressure.
REQ-027 step=0 SHALL leave seg, len, ate (low) and dead unchanged.

Reset
REQ-028 While rst=1, the block SHALL force: seg[k]={4'd2, 4'd3-k} for k<INIT_LEN (head (2,3), body (2,2), (2,1)), len=INIT_LEN, ate=0, dead=0, row_bits=0.
REQ-029 Reset asserted mid-operation SHALL take effect immediately, regardless of clk, and SHALL discard any in-flight step.
REQ-030 The first step SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-031 Reset, then row_sel=2 for one cycle -> row_bits=16'h0004, len=3, dead=0.
REQ-032 After reset, step with head=(2,4) and no food -> seg={(2,4),(2,3),(2,2)}; row_sel=1 gives row_bits=0; len=3.
REQ-033 Step with head=(2,4) and food_valid=1, food=(2,4) -> ate high for exactly one cycle, len=4, tail (2,1) retained.
REQ-034 Build a length-5 body, then steer the head onto the current tail cell (not eating) -> dead stays 0; steer onto seg[1] -> dead=1 the next cycle, and later steps leave len and seg frozen.
REQ-035 With len=MAX_LEN=16, eat again -> ate pulses and len stays 16; head (15,y)->(0,y) -> no dead.
REQ-036 Assert rst between two back-to-back steps -> outputs return to REQ-028 values asynchronously; the second step has no effect.

Source files
------------

// File: rtl/snake_body.sv
// Snake body store: shift-register of segment coordinates with length tracking,
// food consumption, self-collision detection and a registered per-row occupancy readout.
module snake_body #(
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  head_x,
  input  logic [3:0]  head_y,
  input  logic        step,
  input  logic [3:0]  food_x,
  input  logic [3:0]  food_y,
  input  logic        food_valid,
  input  logic [3:0]  row_sel,
  output logic [15:0] row_bits,
  output logic [4:0]  len,
  output logic        ate,
  output logic        dead
);

  logic [7:0]  seg [MAX_LEN];
  logic [7:0]  head;
  logic        eat;
  logic        accept;
  logic        hit;
  logic [4:0]  len_next;
  logic [15:0] row_next;

  assign head   = {head_x, head_y};
  assign eat    = food_valid && (head == {food_x, food_y});
  assign accept = step && !dead;

  // When not eating the tail vacates on this step, so it is excluded from the hit test.
  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < MAX_LEN; k++) begin
      if (((eat && (5'(k) < len)) || ((5'(k) + 5'd1) < len)) && (seg[k] == head))
        hit = 1'b1;
    end
  end

  always_comb begin
    len_next = len;
    if (eat && (len < 5'(MAX_LEN)))
      len_next = len + 5'd1;
  end

  always_comb begin
    row_next = '0;
    for (int k = 0; k < MAX_LEN; k++) begin
      if ((5'(k) < len) && (seg[k][3:0] == row_sel))
        row_next[seg[k][7:4]] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < MAX_LEN; k++)
        seg[k] <= {4'd2, 4'(3 - k)};
      len      <= 5'(INIT_LEN);
      ate      <= 1'b0;
      dead     <= 1'b0;
      row_bits <= '0;
    end else begin
      row_bits <= row_next;
      ate      <= accept && eat;
      if (accept) begin
        for (int k = 1; k < MAX_LEN; k++)
          seg[k] <= seg[k-1];
        seg[0] <= head;
        len    <= len_next;
        if (hit)
          dead <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_snake_body.sv
// Directed bench for snake_body: a reference model predicts ate/len/dead/row_bits,
// expectations are queued at drive time and popped when the DUT result is sampled.
module tb_snake_body;

  logic        clk;
  logic        rst;
  logic [3:0]  head_x, head_y, food_x, food_y, row_sel;
  logic        step, food_valid;
  logic [15:0] row_bits;
  logic [4:0]  len;
  logic        ate, dead;

  snake_body dut (
    .clk(clk), .rst(rst), .head_x(head_x), .head_y(head_y), .step(step),
    .food_x(food_x), .food_y(food_y), .food_valid(food_valid), .row_sel(row_sel),
    .row_bits(row_bits), .len(len), .ate(ate), .dead(dead)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] m_seg [16];
  int         m_len;
  bit         m_dead;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [15:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 16'd1, 16'd0);
    end else begin
      e = sb.pop_front();
      chk(e.tag, obs, e.val);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 16; k++) m_seg[k] = {4'd2, 4'(3 - k)};
    m_len  = 3;
    m_dead = 1'b0;
  endtask

  function automatic logic [15:0] model_row(input logic [3:0] r);
    logic [15:0] b = '0;
    for (int k = 0; k < m_len; k++)
      if (m_seg[k][3:0] == r) b[m_seg[k][7:4]] = 1'b1;
    return b;
  endfunction

  function automatic bit model_step(input logic [7:0] h, input bit fv, input logic [7:0] f);
    bit eat, hit;
    int lim;
    if (m_dead) return 1'b0;
    eat = fv && (h == f);
    lim = eat ? m_len : m_len - 1;
    hit = 1'b0;
    for (int k = 0; k < lim; k++)
      if (m_seg[k] == h) hit = 1'b1;
    for (int k = 15; k > 0; k--) m_seg[k] = m_seg[k-1];
    m_seg[0] = h;
    if (eat && m_len < 16) m_len++;
    if (hit) m_dead = 1'b1;
    return eat;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves step high so back-to-back calls produce consecutive step cycles.
  task automatic do_step(input logic [3:0] hx, input logic [3:0] hy, input bit fv,
                         input logic [3:0] fx, input logic [3:0] fy);
    bit ea;
    head_x = hx; head_y = hy; food_valid = fv; food_x = fx; food_y = fy;
    step = 1'b1;
    ea = model_step({hx, hy}, fv, {fx, fy});
    push("ate", 16'(ea));
    push("len", 16'(m_len));
    push("dead", 16'(m_dead));
    tick();
    pop_chk(16'(ate));
    pop_chk(16'(len));
    pop_chk(16'(dead));
  endtask

  task automatic idle();
    step = 1'b0;
    food_valid = 1'b0;
    push("ate_idle", 16'd0);
    push("len_idle", 16'(m_len));
    tick();
    pop_chk(16'(ate));
    pop_chk(16'(len));
  endtask

  task automatic row(input logic [3:0] r);
    row_sel = r;
    push("row_bits", model_row(r));
    tick();
    pop_chk(row_bits);
  endtask

  task automatic do_reset();
    step = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b0; step = 1'b0; food_valid = 1'b0;
    head_x = '0; head_y = '0; food_x = '0; food_y = '0; row_sel = '0;
    model_reset();
    #1 rst = 1'b1;
    #1;
    chk("rst_len", 16'(len), 16'd3);
    chk("rst_dead", 16'(dead), 16'd0);
    chk("rst_ate", 16'(ate), 16'd0);
    chk("rst_row", row_bits, 16'h0000);
    @(posedge clk);
    #1 rst = 1'b0;

    // Initial body readout
    row(4'd2);
    chk("init_row2", row_bits, 16'h0004);

    // Plain move up: tail (2,1) drops off
    do_step(4'd2, 4'd4, 1'b0, 4'd0, 4'd0);
    idle();
    row(4'd1);
    row(4'd4);
    // Matching coordinates without food_valid must not eat
    do_step(4'd3, 4'd4, 1'b0, 4'd3, 4'd4);
    idle();

    // Eat: length grows and the old tail stays
    do_reset();
    do_step(4'd2, 4'd4, 1'b1, 4'd2, 4'd4);
    idle();
    row(4'd1);
    chk("eat_tail_kept", row_bits, 16'h0004);

    // Grow to 5, move onto the vacating tail (legal), then onto seg[1] (fatal)
    do_step(4'd3, 4'd4, 1'b1, 4'd3, 4'd4);
    do_step(4'd2, 4'd1, 1'b0, 4'd0, 4'd0);
    idle();
    chk("tail_move_alive", 16'(dead), 16'd0);
    do_step(4'd3, 4'd4, 1'b0, 4'd0, 4'd0);
    idle();
    chk("collide_dead", 16'(dead), 16'd1);
    do_step(4'd5, 4'd5, 1'b1, 4'd5, 4'd5);
    do_step(4'd6, 4'd5, 1'b0, 4'd0, 4'd0);
    idle();
    row(4'd4);
    row(4'd1);
    row(4'd5);

    // Saturate at 16 with back-to-back eating steps, then wrap 15 -> 0
    do_reset();
    for (int x = 3; x < 16; x++)
      do_step(4'(x), 4'd5, 1'b1, 4'(x), 4'd5);
    do_step(4'd0, 4'd5, 1'b1, 4'd0, 4'd5);
    chk("sat_len", 16'(len), 16'd16);
    do_step(4'd1, 4'd5, 1'b0, 4'd0, 4'd0);
    idle();
    chk("wrap_alive", 16'(dead), 16'd0);
    row(4'd5);
    row(4'd3);

    // Async reset between two consecutive steps; the second is discarded
    do_reset();
    do_step(4'd2, 4'd4, 1'b1, 4'd2, 4'd4);
    head_x = 4'd2; head_y = 4'd5; food_valid = 1'b1; food_x = 4'd2; food_y = 4'd5;
    #3 rst = 1'b1;
    #1;
    chk("async_len", 16'(len), 16'd3);
    chk("async_ate", 16'(ate), 16'd0);
    chk("async_dead", 16'(dead), 16'd0);
    chk("async_row", row_bits, 16'h0000);
    @(posedge clk);
    #1;
    step = 1'b0;
    food_valid = 1'b0;
    rst = 1'b0;
    model_reset();
    idle();
    row(4'd3);
    row(4'd5);

    chk("sb_empty", 16'(sb.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
